// File: rtl/mem_pkg.sv
// Shared types and widths for the memory responder and its word storage.
package mem_pkg;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned OFS_W      = $clog2(WORD_BYTES);
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;
endpackage

// File: rtl/word_ram.sv
// Word storage: synchronous write port, asynchronous read port, never cleared.
module word_ram
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/memory_responder.sv
// Single-outstanding memory responder: latches a request, waits WAIT_STATES
// cycles, then gives a one-cycle ready with registered rdata/err.
module memory_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [31:0]          lat_addr;
  logic [DATA_W-1:0]    lat_wdata;
  logic                 lat_we;

  logic [31:0]          tgt_addr;
  logic                 tgt_we;
  logic                 tgt_bad;
  logic [IDX_W-1:0]     tgt_idx;
  logic [IDX_W-1:0]     ram_raddr;
  logic [IDX_W-1:0]     ram_waddr;
  logic [DATA_W-1:0]    ram_rdata;
  logic                 ram_we;
  logic [DATA_W-1:0]    resp_rdata;

  // In IDLE the request is entering RESP directly (zero wait states), so use live inputs.
  always_comb begin
    tgt_addr   = (state == IDLE) ? addr : lat_addr;
    tgt_we     = (state == IDLE) ? we : lat_we;
    tgt_bad    = (tgt_addr[OFS_W-1:0] != '0) ||
                 (32'(tgt_addr[31:OFS_W]) >= 32'(DEPTH_WORDS));
    tgt_idx    = IDX_W'(tgt_addr[31:OFS_W]);
    ram_raddr  = tgt_bad ? '0 : tgt_idx;
    resp_rdata = (tgt_bad || tgt_we) ? '0 : ram_rdata;
  end

  // Write lands on the edge closing RESP; err is the latched error for this transaction.
  always_comb begin
    ram_waddr = IDX_W'(lat_addr[31:OFS_W]);
    ram_we    = (state == RESP) && lat_we && !err;
  end

  word_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (lat_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_we    <= 1'b0;
      ready     <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
      case (state)
        IDLE: begin
          if (req) begin
            lat_addr  <= addr;
            lat_we    <= we;
            lat_wdata <= wdata;
            if (WAIT_STATES == 0) begin
              state <= RESP;
              ready <= 1'b1;
              err   <= tgt_bad;
              rdata <= resp_rdata;
            end else begin
              cnt   <= CNT_W'(WAIT_STATES - 1);
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state <= RESP;
            ready <= 1'b1;
            err   <= tgt_bad;
            rdata <= resp_rdata;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench: one responder with two wait states, one with none.
module tb_memory_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_a, we_a, ready_a, err_a;
  logic [31:0] addr_a, wdata_a, rdata_a;
  logic        req_b, we_b, ready_b, err_b;
  logic [31:0] addr_b, wdata_b, rdata_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  memory_responder #(.DEPTH_WORDS(64), .WAIT_STATES(2)) u_dut_a (
    .clk(clk), .reset(reset), .req(req_a), .we(we_a), .addr(addr_a),
    .wdata(wdata_a), .rdata(rdata_a), .ready(ready_a), .err(err_a)
  );

  memory_responder #(.DEPTH_WORDS(64), .WAIT_STATES(0)) u_dut_b (
    .clk(clk), .reset(reset), .req(req_b), .we(we_b), .addr(addr_b),
    .wdata(wdata_b), .rdata(rdata_b), .ready(ready_b), .err(err_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit b, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    if (b) begin
      req_b = r; we_b = w; addr_b = a; wdata_b = d;
    end else begin
      req_a = r; we_a = w; addr_a = a; wdata_a = d;
    end
  endtask

  function automatic logic rdy(input bit b);
    return b ? ready_b : ready_a;
  endfunction

  // One transaction; lat = posedges from the sampling edge through the edge raising ready.
  task automatic xact(input bit b, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input bit hold, input bit scram,
                      output logic [31:0] rd, output logic e, output int lat);
    int  n;
    int  extra;
    bit  seen;
    n = 0; seen = 0; rd = '0; e = 1'b0; extra = 0;
    @(negedge clk);
    drive(b, 1'b1, w, a, d);
    while (!seen && n < 40) begin
      @(posedge clk);
      n++;
      if (scram && n == 1) begin
        #1 drive(b, 1'b1, ~w, a ^ 32'h18, ~d);
      end
      @(negedge clk);
      if (rdy(b)) begin
        seen = 1;
        rd   = b ? rdata_b : rdata_a;
        e    = b ? err_b : err_a;
      end
    end
    lat = seen ? n : -1;
    if (!hold) drive(b, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("ready_one_cycle", 32'(rdy(b)), 32'd0);
    drive(b, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rdy(b)) extra++;
    end
    check("no_extra_ready", 32'(extra), 32'd0);
  endtask

  logic [31:0] rd;
  logic        e;
  int          lat;
  int          pulses[$];
  int          cnt_r;

  initial begin
    reset = 1'b0;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready_a", 32'(ready_a), 32'd0);
    check("rst_err_a",   32'(err_a),   32'd0);
    check("rst_rdata_a", rdata_a,      32'd0);
    check("rst_ready_b", 32'(ready_b), 32'd0);
    check("rst_rdata_b", rdata_b,      32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Write then read back with two wait states.
    xact(0, 1'b1, 32'h8, 32'hDEADBEEF, 0, 0, rd, e, lat);
    check("wr8_lat", 32'(lat), 32'd3);
    check("wr8_err", 32'(e), 32'd0);
    check("wr8_rdata", rd, 32'd0);
    xact(0, 1'b0, 32'h8, '0, 0, 0, rd, e, lat);
    check("rd8_lat", 32'(lat), 32'd3);
    check("rd8_rdata", rd, 32'hDEADBEEF);
    check("rd8_err", 32'(e), 32'd0);

    // Misaligned write must not disturb its neighbour.
    xact(0, 1'b1, 32'h4, 32'h11112222, 0, 0, rd, e, lat);
    xact(0, 1'b1, 32'h6, 32'h12345678, 0, 0, rd, e, lat);
    check("mis_err", 32'(e), 32'd1);
    check("mis_rdata", rd, 32'd0);
    check("mis_lat", 32'(lat), 32'd3);
    xact(0, 1'b0, 32'h4, '0, 0, 0, rd, e, lat);
    check("rd4_rdata", rd, 32'h11112222);
    check("rd4_err", 32'(e), 32'd0);

    // Range boundaries: last word is valid, one past the end is not.
    xact(0, 1'b1, 32'hFC, 32'hCAFEF00D, 0, 0, rd, e, lat);
    check("wrFC_err", 32'(e), 32'd0);
    xact(0, 1'b0, 32'hFC, '0, 0, 0, rd, e, lat);
    check("rdFC_rdata", rd, 32'hCAFEF00D);
    xact(0, 1'b0, 32'h100, '0, 0, 0, rd, e, lat);
    check("oor_err", 32'(e), 32'd1);
    check("oor_rdata", rd, 32'd0);

    // Reset during WAIT aborts the write.
    xact(0, 1'b1, 32'hC, 32'h0C0C0C0C, 0, 0, rd, e, lat);
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'hC, 32'hBAD0BAD0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rstw_ready", 32'(ready_a), 32'd0);
    check("rstw_err", 32'(err_a), 32'd0);
    check("rstw_rdata", rdata_a, 32'd0);
    cnt_r = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (ready_a) cnt_r++;
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ready_a) cnt_r++;
    end
    check("rstw_no_ready", 32'(cnt_r), 32'd0);
    xact(0, 1'b0, 32'hC, '0, 0, 0, rd, e, lat);
    check("rdC_lat", 32'(lat), 32'd3);
    check("rdC_rdata", rd, 32'h0C0C0C0C);

    // req held through RESP, address/we/wdata scrambled during WAIT.
    xact(0, 1'b1, 32'h10, 32'h55AA55AA, 0, 0, rd, e, lat);
    xact(0, 1'b0, 32'h10, 32'h0, 1, 1, rd, e, lat);
    check("hold_rdata", rd, 32'h55AA55AA);
    check("hold_lat", 32'(lat), 32'd3);
    xact(0, 1'b0, 32'h10, '0, 0, 0, rd, e, lat);
    check("hold_after", rd, 32'h55AA55AA);
    xact(0, 1'b0, 32'h8, '0, 0, 0, rd, e, lat);
    check("scram_target", rd, 32'hDEADBEEF);

    // Zero wait states.
    xact(1, 1'b0, 32'h0, '0, 0, 0, rd, e, lat);
    check("ws0_rd_lat", 32'(lat), 32'd1);
    xact(1, 1'b1, 32'h0, 32'hA5A5A5A5, 0, 0, rd, e, lat);
    check("ws0_wr_lat", 32'(lat), 32'd1);
    xact(1, 1'b0, 32'h0, '0, 0, 0, rd, e, lat);
    check("ws0_rdata", rd, 32'hA5A5A5A5);

    // Back-to-back with req held: ready every second cycle.
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 32'h0, '0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ready_b) pulses.push_back(i);
    end
    drive(1, 1'b0, 1'b0, '0, '0);
    check("b2b_count", 32'(pulses.size()), 32'd4);
    if (pulses.size() >= 2) begin
      check("b2b_first", 32'(pulses[0]), 32'd0);
      check("b2b_space", 32'(pulses[1] - pulses[0]), 32'd2);
    end else begin
      check("b2b_space", 32'(pulses.size()), 32'd4);
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
